// File: rtl/tiled_row_accumulator_pkg.sv
// Shared types and defaults for the tiled row accumulator.
package tiled_row_accumulator_pkg;

    localparam int NUM_BITS          = 8;
    localparam int N                 = 4;
    localparam int ACC_LANES_DEFAULT = 1;

    typedef enum logic {
        ACC_FILL = 1'b0,
        ACC_HOLD = 1'b1
    } acc_state_e;

endpackage

// File: rtl/tiled_row_accumulator_acc_lane_add.sv
// One lane of the rotate-accumulate datapath: data + (en ? stored : 0).
// Define ACC_SATURATE_EN to clamp accumulating sums at 2^WIDTH-1 and flag overflow.
module acc_lane_add
    import tiled_row_accumulator_pkg::*;
#(
    parameter int WIDTH = NUM_BITS
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] addend;

    assign addend = en_i ? acc_i : {WIDTH{1'b0}};

`ifdef ACC_SATURATE_EN
    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, data_i} + {1'b0, addend};
    assign sum_o    = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
    assign ovf_o    = full_sum[WIDTH];
`else
    assign sum_o = data_i + addend;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/tiled_row_accumulator.sv
// Collects one output row, LANES elements per beat, over one or more K-passes.
// Saturating accumulation is enabled by defining ACC_SATURATE_EN.
module tiled_row_accumulator
    import tiled_row_accumulator_pkg::*;
#(
    parameter int WIDTH = NUM_BITS,
    parameter int DEPTH = N,
    parameter int LANES = ACC_LANES_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES-1:0][WIDTH-1:0] in_data_i,
    input  logic                        in_accum_i,
    input  logic                        in_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DEPTH-1:0][WIDTH-1:0] out_data_o,
    output logic                        ovf_o
);

    localparam int BEATS = DEPTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (DEPTH % LANES != 0) begin : g_bad_cfg
        $error("tiled_row_accumulator: DEPTH must be a multiple of LANES");
    end

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ready_en_q, ready_en_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic             lane_ovf [LANES];
    logic             accept;
    logic             any_ovf;

    // Lanes fold the oldest LANES elements into the incoming beat; the rest slide up.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        acc_lane_add #(.WIDTH(WIDTH)) u_add (
            .en_i   (in_accum_i),
            .acc_i  (data_q[DEPTH-LANES+gi]),
            .data_i (in_data_i[gi]),
            .sum_o  (shifted[gi]),
            .ovf_o  (lane_ovf[gi])
        );
    end

    for (genvar gi = LANES; gi < DEPTH; gi++) begin : g_shift
        assign shifted[gi] = data_q[gi-LANES];
    end

    assign in_ready_o  = (state_q == ACC_FILL) && ready_en_q;
    assign out_valid_o = (state_q == ACC_HOLD);
    assign ovf_o       = ovf_q;
    assign accept      = in_valid_i && in_ready_o;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            out_data_o[i] = data_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        data_d     = data_q;
        ready_en_d = 1'b1;
        any_ovf    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            any_ovf = any_ovf | lane_ovf[i];
        end
        case (state_q)
            ACC_FILL: begin
                if (accept) begin
                    data_d = shifted;
                    ovf_d  = ovf_q | any_ovf;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (in_last_i) begin
                            state_d = ACC_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACC_HOLD: begin
                if (out_ready_i) begin
                    state_d = ACC_FILL;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC_FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACC_FILL;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ready_en_q <= 1'b0;
            data_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ready_en_q <= ready_en_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_tiled_row_accumulator.sv
// Directed scoreboard bench for tiled_row_accumulator (LANES=1 and LANES=2 instances).
module tb_tiled_row_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            v0 = 1'b0, acc0 = 1'b0, last0 = 1'b0, ordy0 = 1'b0;
    logic [0:0][7:0] d0 = '0;
    logic            rdy0, ov0, ovf0;
    logic [3:0][7:0] od0;

    logic            v1 = 1'b0, acc1 = 1'b0, last1 = 1'b0, ordy1 = 1'b0;
    logic [1:0][7:0] d1 = '0;
    logic            rdy1, ov1, ovf1;
    logic [3:0][7:0] od1;

    tiled_row_accumulator #(.WIDTH(8), .DEPTH(4), .LANES(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_ready_o(rdy0),
        .in_data_i(d0), .in_accum_i(acc0), .in_last_i(last0),
        .out_valid_o(ov0), .out_ready_i(ordy0), .out_data_o(od0), .ovf_o(ovf0)
    );

    tiled_row_accumulator #(.WIDTH(8), .DEPTH(4), .LANES(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(rdy1),
        .in_data_i(d1), .in_accum_i(acc1), .in_last_i(last1),
        .out_valid_o(ov1), .out_ready_i(ordy1), .out_data_o(od1), .ovf_o(ovf1)
    );

    typedef struct packed {
        logic [3:0][7:0] row;
        logic            ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   rows0 = 0;
    int   rows1 = 0;
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;

`ifdef ACC_SATURATE_EN
    localparam logic [7:0] OVF_RES  = 8'd255;
    localparam logic       OVF_FLAG = 1'b1;
`else
    localparam logic [7:0] OVF_RES  = 8'd44;
    localparam logic       OVF_FLAG = 1'b0;
`endif

    function automatic logic [3:0][7:0] mk(input logic [7:0] a0, a1, a2, a3);
        mk = {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic beat0(input logic [7:0] val, input logic a, input logic l);
        int n = 0;
        while (!rdy0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy0) chk("beat0_ready_timeout", {31'b0, rdy0}, 32'd1);
        d0[0] = val; acc0 = a; last0 = l; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; acc0 = 1'b0; last0 = 1'b0;
        $display("dut0 beat data=%0d accum=%0b last=%0b", val, a, l);
    endtask

    task automatic beat1(input logic [7:0] l0, input logic [7:0] l1, input logic a, input logic l);
        int n = 0;
        while (!rdy1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy1) chk("beat1_ready_timeout", {31'b0, rdy1}, 32'd1);
        d1[0] = l0; d1[1] = l1; acc1 = a; last1 = l; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; acc1 = 1'b0; last1 = 1'b0;
        $display("dut1 beat data={%0d,%0d} accum=%0b last=%0b", l0, l1, a, l);
    endtask

    task automatic hs0();
        ordy0 = 1'b1;
        @(posedge clk); #1;
        ordy0 = 1'b0;
        $display("dut0 row handshake");
    endtask

    task automatic hs1();
        ordy1 = 1'b1;
        @(posedge clk); #1;
        ordy1 = 1'b0;
        $display("dut1 row handshake");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        fork
            forever begin
                @(negedge clk);
                if (ov0 && !pv0) begin
                    rows0++;
                    if (q0.size() == 0) begin
                        chk("row0_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        $display("dut0 row out=%h ovf=%b", od0, ovf0);
                        chk("row0_data", od0, e.row);
                        chk("row0_ovf", {31'b0, ovf0}, {31'b0, e.ovf});
                    end
                end
                if (ov1 && !pv1) begin
                    rows1++;
                    if (q1.size() == 0) begin
                        chk("row1_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        $display("dut1 row out=%h ovf=%b", od1, ovf1);
                        chk("row1_data", od1, e.row);
                        chk("row1_ovf", {31'b0, ovf1}, {31'b0, e.ovf});
                    end
                end
                pv0 = ov0;
                pv1 = ov1;
            end
        join_none

        // Reset state
        #2;
        chk("rst_valid0", {31'b0, ov0}, 32'd0);
        chk("rst_ready0", {31'b0, rdy0}, 32'd0);
        chk("rst_data0", od0, 32'd0);
        chk("rst_ovf0", {31'b0, ovf0}, 32'd0);
        chk("rst_ready1", {31'b0, rdy1}, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready0_after_release", {31'b0, rdy0}, 32'd1);

        // Single-pass row
        q0.push_back(exp_t'{mk(8'd4, 8'd3, 8'd2, 8'd1), 1'b0});
        beat0(8'd1, 1'b0, 1'b0);
        beat0(8'd2, 1'b0, 1'b0);
        beat0(8'd3, 1'b0, 1'b0);
        beat0(8'd4, 1'b0, 1'b1);
        chk("t1_valid", {31'b0, ov0}, 32'd1);
        chk("t1_ready", {31'b0, rdy0}, 32'd0);
        hs0();
        chk("t1_ready_after_hs", {31'b0, rdy0}, 32'd1);
        chk("t1_valid_after_hs", {31'b0, ov0}, 32'd0);

        // Two-pass accumulate
        beat0(8'd1, 1'b0, 1'b0);
        beat0(8'd2, 1'b0, 1'b0);
        beat0(8'd3, 1'b0, 1'b0);
        beat0(8'd4, 1'b0, 1'b0);
        q0.push_back(exp_t'{mk(8'd14, 8'd13, 8'd12, 8'd11), 1'b0});
        beat0(8'd10, 1'b1, 1'b0);
        beat0(8'd10, 1'b1, 1'b0);
        beat0(8'd10, 1'b1, 1'b0);
        beat0(8'd10, 1'b1, 1'b1);

        // Backpressure with input still offered
        d0[0] = 8'd99; acc0 = 1'b0; last0 = 1'b1; v0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_valid_held", {31'b0, ov0}, 32'd1);
            chk("t3_ready_low", {31'b0, rdy0}, 32'd0);
            chk("t3_data_stable", od0, mk(8'd14, 8'd13, 8'd12, 8'd11));
        end
        v0 = 1'b0; last0 = 1'b0;
        hs0();
        chk("t3_ready_after_hs", {31'b0, rdy0}, 32'd1);
        chk("t3_valid_after_hs", {31'b0, ov0}, 32'd0);
        chk("t3_data_kept", od0, mk(8'd14, 8'd13, 8'd12, 8'd11));

        // Two lanes
        q1.push_back(exp_t'{mk(8'd7, 8'd8, 8'd5, 8'd6), 1'b0});
        beat1(8'd5, 8'd6, 1'b0, 1'b0);
        beat1(8'd7, 8'd8, 1'b0, 1'b1);
        chk("t4_valid1", {31'b0, ov1}, 32'd1);
        hs1();
        chk("t4_ready1_after_hs", {31'b0, rdy1}, 32'd1);

        // Overflow: 200 stored, then accumulate 100 at the same position
        beat0(8'd200, 1'b0, 1'b0);
        beat0(8'd0, 1'b0, 1'b0);
        beat0(8'd0, 1'b0, 1'b0);
        beat0(8'd0, 1'b0, 1'b0);
        q0.push_back(exp_t'{mk(8'd0, 8'd0, 8'd0, OVF_RES), OVF_FLAG});
        beat0(8'd100, 1'b1, 1'b0);
        beat0(8'd0, 1'b1, 1'b0);
        beat0(8'd0, 1'b1, 1'b0);
        beat0(8'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("t5_ovf_held", {31'b0, ovf0}, {31'b0, OVF_FLAG});
        hs0();
        chk("t5_ovf_cleared", {31'b0, ovf0}, 32'd0);

        // Reset mid-pass
        beat0(8'd7, 1'b0, 1'b0);
        beat0(8'd7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_data_cleared", od0, 32'd0);
        chk("t6_valid_low", {31'b0, ov0}, 32'd0);
        chk("t6_ready_in_reset", {31'b0, rdy0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready_after_release", {31'b0, rdy0}, 32'd1);
        q0.push_back(exp_t'{mk(8'd9, 8'd9, 8'd9, 8'd9), 1'b0});
        beat0(8'd9, 1'b0, 1'b0);
        beat0(8'd9, 1'b0, 1'b0);
        beat0(8'd9, 1'b0, 1'b0);
        beat0(8'd9, 1'b0, 1'b1);
        chk("t6_valid", {31'b0, ov0}, 32'd1);
        hs0();

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("rows0_seen", rows0, 32'd4);
        chk("rows1_seen", rows1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiled_row_accumulator.md
Name: tiled_row_accumulator

Overview:
- Parametrised successor to the single-lane C-element shift collector.
- Collects one output row of the systolic matrix multiply, LANES elements per beat, into DEPTH result registers.
- Supports multi-pass K-tiling: each pass either overwrites or accumulates onto the stored partial sums.
- Presents the completed row with a valid/ready handshake to the writeback stage.

Parameters:
- WIDTH, default NUM_BITS: bits per element.
- DEPTH, default N: elements per row. DEPTH % LANES == 0 is required; elaboration-time assertion.
- LANES, default 1: elements accepted per beat.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- in_data_i  in  [LANES] x WIDTH  partial-sum elements.
- in_accum_i  in  1  1: add to stored value; 0: overwrite.
- in_last_i  in  1  marks the final K-pass; sampled only on a pass's final beat.
- out_valid_o  out  1  completed row available.
- out_ready_i  in  1  downstream accepts row.
- out_data_o  out  [DEPTH] x WIDTH  row registers; index 0 holds the newest element.
- ovf_o  out  1  sticky overflow flag for the current row.

Behaviour:
- Single clock domain (clk_i). rst_i is asynchronous and active-high; it is decided and not configurable.
- Reset (immediate, asynchronous) sets:
  - all out_data_o to 0
  - beat counter to 0
  - state to FILL
  - out_valid_o = 0, ovf_o = 0
  - in_ready_o = 0 while rst_i is high, 1 from the first cycle after release.
- BEATS = DEPTH/LANES. Beat counter runs 0..BEATS-1 and wraps on acceptance of beat BEATS-1 (end of pass).
- FSM has two states:
  - FILL: in_ready_o = 1, out_valid_o = 0.
  - HOLD: in_ready_o = 0, out_valid_o = 1; out_data_o and ovf_o are stable.
- On an accepted beat in FILL (rotate-accumulate):
  - For j < LANES: out_data_o[j] <= in_data_i[j] + (in_accum_i ? out_data_o[DEPTH-LANES+j] : 0).
  - For j >= LANES: out_data_o[j] <= out_data_o[j-LANES].
  - After BEATS beats, every element is back at its original index.
- No accepted beat (in_valid_i = 0): registers and counter hold.
- Accepted final beat with in_last_i = 1: next state HOLD; out_valid_o rises the following cycle, so latency is 1 cycle after the last beat.
- Accepted final beat with in_last_i = 0: stay in FILL and start the next pass. in_last_i on non-final beats is ignored.
- in_accum_i is applied per beat. The first pass of a row must use in_accum_i = 0; the block does not clear registers between rows.
- HOLD -> FILL when out_ready_i = 1. out_data_o keeps its value after the handshake.
- In HOLD, in_valid_i is ignored. There is no same-cycle bypass, so a one-cycle input bubble follows each row.
- ovf_o clears on the cycle the row handshake completes.
- Arithmetic is unsigned. Without the optional feature, sums wrap modulo 2^WIDTH.
- Reset mid-pass discards the partial row.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined:
  - Accumulating adds saturate to 2^WIDTH-1.
  - Any saturation sets ovf_o, which stays set until the row handshake or reset.
- Undefined:
  - Adds wrap.
  - ovf_o is tied to 0.

Decomposition:
- Shared package pkg gains:
  - typedef acc_state_e {ACC_FILL, ACC_HOLD}
  - constant ACC_LANES_DEFAULT = 1
  - reuse of NUM_BITS and N.
- Sub-module acc_lane_add: one WIDTH-bit adder with enable, optional saturation and an overflow output. It is instantiated LANES times.
- The FSM, counter and shift network stay in the top module.

Test Plan (WIDTH=8, DEPTH=4, LANES=1 unless noted):
1. Single-pass row: after reset, beats 1,2,3,4 with accum=0, last=1 on beat 4 -> next cycle out_valid_o=1, in_ready_o=0, out_data_o[0..3] = 4,3,2,1.
2. Two-pass accumulate: pass 1 = 1,2,3,4 with last=0; pass 2 = 10,10,10,10 with accum=1, last=1 -> out_data_o[0..3] = 14,13,12,11.
3. Backpressure: hold out_ready_i=0 for 5 cycles while driving in_valid_i=1 -> out_valid_o stays 1, data is stable, no beats are accepted. Raise out_ready_i -> FILL and in_ready_o=1 the next cycle.
4. LANES=2: beats {5,6} then {7,8} with last=1 -> out_data_o[0..3] = 7,8,5,6.
5. Overflow: stored 200, then accum beat 100 at the same index:
   - Macro undefined -> result 44, ovf_o=0.
   - ACC_SATURATE_EN defined -> result 255, ovf_o=1 until the row handshake.
6. Reset mid-pass: assert rst_i after 2 accepted beats -> out_data_o is all 0 immediately and out_valid_o=0. A fresh 4-beat row 9,9,9,9 after release then completes normally.
